// File: rtl/pre_fetch_stage.sv
// pre_fetch_stage
//  Pre-IF stage. It owns the fetch PC, sends I-cache address requests and
//  hands one entry at a time to the IF stage over pfs_to_fs_bus.
//  - An entry becomes ready once its request has been accepted (WAIT), once
//    its instruction is buffered here (HOLD), or immediately if the PC is
//    misaligned (AdEL, with no request issued).
//  - Responses that arrive before IF takes the entry are buffered in inst_buf.
//  - Redirects: pipeline_flush wins over bpu_flush. A BPU redirect that
//    arrives while the held entry is a delay slot is deferred until that
//    entry has transferred.
//  - A redirect that leaves a request in flight moves to CANCEL. The first
//    response this stage owns is then dropped.
//
//  Handshake: an entry moves to IF on a cycle where bus.valid && ready_go &&
//  fs_allowin. The I-cache accepts a request on a cycle where
//  icache_req && icache_addr_ok. Responses come back in request order. A
//  response is owned by this stage only when IF has no pending request
//  (fs_inst_pending == 0).
//
// Ports
//  clk, reset          clock, synchronous active-high reset
//  fs_allowin          IF can accept an entry this cycle
//  fs_inst_pending     IF owns the next data_ok
//  br_op               IF is passing a branch/jump to ID this cycle
//  bpu_flush/target    BPU redirect request and PC
//  pipeline_flush      .flush=1 redirects to flush_target
//  flush_target        redirect PC for pipeline_flush
//  icache_*            I-cache request/response channel
//  pfs_to_fs_bus       entry presented to IF
//  fsm_state           current FSM state, for observation

package pre_fetch_pkg;

  typedef struct packed {
    logic flush;
  } pipeline_flush_t;

  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } exception_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic        br_op;
    logic        data_cancel;
    exception_t  exception;
  } pfs_to_fs_bus_t;

  typedef enum logic [1:0] {
    PFS_REQ    = 2'd0,
    PFS_WAIT   = 2'd1,
    PFS_HOLD   = 2'd2,
    PFS_CANCEL = 2'd3
  } pfs_state_e;

  localparam logic [4:0] EXC_ADEL = 5'h04;

endpackage

module pre_fetch_stage
  import pre_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fs_allowin,
  input  logic            fs_inst_pending,
  input  logic            br_op,
  input  logic            bpu_flush,
  input  logic [31:0]     bpu_target,
  input  pipeline_flush_t pipeline_flush,
  input  logic [31:0]     flush_target,
  output logic            icache_req,
  output logic [31:0]     icache_addr,
  input  logic            icache_addr_ok,
  input  logic            icache_data_ok,
  input  logic [31:0]     icache_rdata,
  output pfs_to_fs_bus_t  pfs_to_fs_bus,
  output pfs_state_e      fsm_state
);

  logic        started;        // low only in the cycles straight out of reset
  logic [31:0] pc;
  pfs_state_e  state;
  logic [31:0] inst_buf;
  logic        inst_valid;
  logic        ds_flag;        // the held entry is a delay slot
  logic        pend_redirect;
  logic [31:0] pend_pc;

  logic        misaligned;
  logic        ex;
  logic        ready_go;
  logic        fire;
  logic        own_data;
  logic        req_accepted;
  logic        outstanding;
  logic        bus_br_op;
  logic        redirect_now;
  logic        bpu_defer;
  logic [31:0] redirect_pc;

  always_comb begin
    misaligned   = (pc[1:0] != 2'b00);
    ex           = started && misaligned;
    icache_req   = started && (state == PFS_REQ) && !misaligned;
    icache_addr  = pc;
    ready_go     = (state == PFS_WAIT) || (state == PFS_HOLD) || ex;
    fire         = started && ready_go && fs_allowin;
    own_data     = icache_data_ok && !fs_inst_pending &&
                   ((state == PFS_WAIT) || (state == PFS_CANCEL));
    req_accepted = icache_req && icache_addr_ok;
    // A request is still in flight if it is accepted this cycle, or if a
    // WAIT/CANCEL request has not had its response this cycle.
    outstanding  = req_accepted ||
                   (((state == PFS_WAIT) || (state == PFS_CANCEL)) && !own_data);
    bus_br_op    = started && (ds_flag || br_op);
    redirect_now = pipeline_flush.flush || (bpu_flush && !bus_br_op);
    bpu_defer    = !pipeline_flush.flush && bpu_flush && bus_br_op;
    redirect_pc  = pipeline_flush.flush ? flush_target : bpu_target;
  end

  always_comb begin
    pfs_to_fs_bus                    = '0;
    pfs_to_fs_bus.valid              = started;
    pfs_to_fs_bus.pc                 = pc;
    pfs_to_fs_bus.inst_valid         = started && inst_valid;
    pfs_to_fs_bus.inst               = inst_buf;
    pfs_to_fs_bus.br_op              = bus_br_op;
    pfs_to_fs_bus.data_cancel        = started && (state == PFS_CANCEL);
    pfs_to_fs_bus.exception.ex       = ex;
    pfs_to_fs_bus.exception.exccode  = ex ? EXC_ADEL : 5'h00;
    pfs_to_fs_bus.exception.badvaddr = ex ? pc : 32'h0;
    fsm_state                        = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      started       <= 1'b0;
      pc            <= RESET_PC;
      state         <= PFS_REQ;
      inst_buf      <= 32'h0;
      inst_valid    <= 1'b0;
      ds_flag       <= 1'b0;
      pend_redirect <= 1'b0;
      pend_pc       <= 32'h0;
    end else begin
      started <= 1'b1;

      case (state)
        PFS_REQ:    if (req_accepted) state <= PFS_WAIT;
        PFS_WAIT:   if (own_data) begin
                      inst_buf   <= icache_rdata;
                      inst_valid <= 1'b1;
                      state      <= PFS_HOLD;
                    end
        PFS_HOLD:   ;
        PFS_CANCEL: if (own_data) state <= PFS_REQ;
        default:    state <= PFS_REQ;
      endcase

      if (br_op && started) ds_flag <= 1'b1;

      // A transfer hands any in-flight request to IF, so the next state is
      // always REQ. When the entry transfers in the same cycle as its own
      // data_ok, IF takes icache_rdata directly.
      if (fire) begin
        pc            <= pend_redirect ? pend_pc : pc + 32'd4;
        state         <= PFS_REQ;
        inst_valid    <= 1'b0;
        ds_flag       <= 1'b0;
        pend_redirect <= 1'b0;
      end

      if (redirect_now) begin
        pc            <= redirect_pc;
        inst_valid    <= 1'b0;
        ds_flag       <= 1'b0;
        pend_redirect <= 1'b0;
        state         <= (!fire && outstanding) ? PFS_CANCEL : PFS_REQ;
      end else if (bpu_defer) begin
        // The delay slot must still go out. If it leaves now, jump at once.
        // Otherwise remember the target for the next transfer.
        if (fire) begin
          pc <= bpu_target;
        end else begin
          pend_redirect <= 1'b1;
          pend_pc       <= bpu_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_pre_fetch_stage.sv
// Directed bench for pre_fetch_stage. Inputs are driven just after the
// falling edge. Outputs are checked 1ns later, well away from the rising edge.
module tb_pre_fetch_stage;
  import pre_fetch_pkg::*;

  logic            clk;
  logic            reset;
  logic            fs_allowin;
  logic            fs_inst_pending;
  logic            br_op;
  logic            bpu_flush;
  logic [31:0]     bpu_target;
  pipeline_flush_t pipeline_flush;
  logic [31:0]     flush_target;
  logic            icache_req;
  logic [31:0]     icache_addr;
  logic            icache_addr_ok;
  logic            icache_data_ok;
  logic [31:0]     icache_rdata;
  pfs_to_fs_bus_t  bus;
  pfs_state_e      fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  pre_fetch_stage #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .fs_allowin      (fs_allowin),
    .fs_inst_pending (fs_inst_pending),
    .br_op           (br_op),
    .bpu_flush       (bpu_flush),
    .bpu_target      (bpu_target),
    .pipeline_flush  (pipeline_flush),
    .flush_target    (flush_target),
    .icache_req      (icache_req),
    .icache_addr     (icache_addr),
    .icache_addr_ok  (icache_addr_ok),
    .icache_data_ok  (icache_data_ok),
    .icache_rdata    (icache_rdata),
    .pfs_to_fs_bus   (bus),
    .fsm_state       (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    fs_allowin           = 1'b0;
    fs_inst_pending      = 1'b0;
    br_op                = 1'b0;
    bpu_flush            = 1'b0;
    bpu_target           = 32'h0;
    pipeline_flush.flush = 1'b0;
    flush_target         = 32'h0;
    icache_addr_ok       = 1'b0;
    icache_data_ok       = 1'b0;
    icache_rdata         = 32'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    #1;
    chk("rst_req",   32'(icache_req), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_pc",    bus.pc, 32'hbfc0_0000);
    chk("rst_state", 32'(fsm_state), 32'(PFS_REQ));
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    clear_inputs();

    // 1: requests in order with addr_ok always high and IF always ready
    do_reset();
    icache_addr_ok = 1'b1;
    fs_allowin     = 1'b1;
    exp_q.push_back(32'hbfc0_0000);
    exp_q.push_back(32'hbfc0_0004);
    exp_q.push_back(32'hbfc0_0008);
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      #1;
      if (icache_req && icache_addr_ok) chk("seq_addr", icache_addr, exp_q.pop_front());
      budget++;
      cycle();
    end
    chk("seq_done", 32'(exp_q.size()), 32'd0);

    // 2: an early response is buffered while IF stalls
    do_reset();
    icache_addr_ok = 1'b1;
    #1 chk("hold_req", icache_addr, 32'hbfc0_0000);
    cycle();
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b1;
    icache_rdata   = 32'h2402_0001;
    #1 chk("hold_wait_iv", 32'(bus.inst_valid), 32'd0);
    cycle();
    icache_data_ok = 1'b0;
    icache_rdata   = 32'h0;
    #1;
    chk("hold_iv",    32'(bus.inst_valid), 32'd1);
    chk("hold_inst",  bus.inst, 32'h2402_0001);
    chk("hold_noreq", 32'(icache_req), 32'd0);
    cycle();
    #1 chk("hold_state", 32'(fsm_state), 32'(PFS_HOLD));
    fs_allowin = 1'b1;
    #1 chk("hold_xfer_pc", bus.pc, 32'hbfc0_0000);
    cycle();
    fs_allowin = 1'b0;
    #1;
    chk("hold_next_req",  32'(icache_req), 32'd1);
    chk("hold_next_addr", icache_addr, 32'hbfc0_0004);
    chk("hold_next_iv",   32'(bus.inst_valid), 32'd0);

    // 3: a flush during WAIT cancels the response that is still owed
    do_reset();
    icache_addr_ok = 1'b1;
    cycle();
    icache_addr_ok       = 1'b0;
    pipeline_flush.flush = 1'b1;
    flush_target         = 32'hbfc0_0380;
    cycle();
    pipeline_flush.flush = 1'b0;
    #1;
    chk("cxl_state", 32'(fsm_state), 32'(PFS_CANCEL));
    chk("cxl_noreq", 32'(icache_req), 32'd0);
    chk("cxl_dc",    32'(bus.data_cancel), 32'd1);
    icache_data_ok = 1'b1;
    icache_rdata   = 32'hdead_beef;
    cycle();
    icache_data_ok = 1'b0;
    #1;
    chk("cxl_req",  32'(icache_req), 32'd1);
    chk("cxl_addr", icache_addr, 32'hbfc0_0380);
    chk("cxl_iv",   32'(bus.inst_valid), 32'd0);

    // 4: a BPU redirect while holding a delay slot is deferred
    do_reset();
    icache_addr_ok = 1'b1;
    cycle();
    icache_addr_ok = 1'b0;
    br_op          = 1'b1;
    icache_data_ok = 1'b1;
    icache_rdata   = 32'h1111_1111;
    #1 chk("ds_brop_live", 32'(bus.br_op), 32'd1);
    cycle();
    br_op          = 1'b0;
    icache_data_ok = 1'b0;
    bpu_flush      = 1'b1;
    bpu_target     = 32'h8000_1000;
    #1 chk("ds_brop_flag", 32'(bus.br_op), 32'd1);
    cycle();
    bpu_flush  = 1'b0;
    fs_allowin = 1'b1;
    #1;
    chk("ds_xfer_pc",   bus.pc, 32'hbfc0_0000);
    chk("ds_xfer_brop", 32'(bus.br_op), 32'd1);
    chk("ds_xfer_iv",   32'(bus.inst_valid), 32'd1);
    cycle();
    fs_allowin = 1'b0;
    #1;
    chk("ds_tgt_addr", icache_addr, 32'h8000_1000);
    chk("ds_tgt_req",  32'(icache_req), 32'd1);
    chk("ds_tgt_brop", 32'(bus.br_op), 32'd0);

    // 5: a BPU redirect with no branch in IF takes effect at once
    icache_addr_ok = 1'b1;
    cycle();
    icache_addr_ok = 1'b0;
    icache_data_ok = 1'b1;
    icache_rdata   = 32'h2222_2222;
    cycle();
    icache_data_ok = 1'b0;
    bpu_flush      = 1'b1;
    bpu_target     = 32'h8000_2000;
    cycle();
    bpu_flush = 1'b0;
    #1;
    chk("bpu_addr",  icache_addr, 32'h8000_2000);
    chk("bpu_req",   32'(icache_req), 32'd1);
    chk("bpu_iv",    32'(bus.inst_valid), 32'd0);
    cycle();

    // 6: a misaligned flush target raises AdEL with no request
    pipeline_flush.flush = 1'b1;
    flush_target         = 32'hbfc0_0382;
    cycle();
    pipeline_flush.flush = 1'b0;
    #1;
    chk("adel_noreq", 32'(icache_req), 32'd0);
    chk("adel_ex",    32'(bus.exception.ex), 32'd1);
    chk("adel_code",  32'(bus.exception.exccode), 32'h04);
    chk("adel_bad",   bus.exception.badvaddr, 32'hbfc0_0382);
    fs_allowin = 1'b1;
    cycle();
    fs_allowin = 1'b0;
    #1 chk("adel_next_bad", bus.exception.badvaddr, 32'hbfc0_0386);

    // 7: the PC wraps from ffff_fffc to 0
    pipeline_flush.flush = 1'b1;
    flush_target         = 32'hffff_fffc;
    cycle();
    pipeline_flush.flush = 1'b0;
    icache_addr_ok       = 1'b1;
    #1 chk("wrap_top", icache_addr, 32'hffff_fffc);
    cycle();
    icache_addr_ok = 1'b0;
    fs_allowin     = 1'b1;
    cycle();
    fs_allowin = 1'b0;
    #1 chk("wrap_zero", icache_addr, 32'h0000_0000);

    // 8: a redirect in the same cycle as addr_ok leads to CANCEL. A response
    //    owned by IF is ignored, and the first own response is dropped.
    icache_addr_ok       = 1'b1;
    pipeline_flush.flush = 1'b1;
    flush_target         = 32'hbfc0_0000;
    cycle();
    icache_addr_ok       = 1'b0;
    pipeline_flush.flush = 1'b0;
    icache_data_ok       = 1'b1;
    fs_inst_pending      = 1'b1;
    #1 chk("ao_cxl_state", 32'(fsm_state), 32'(PFS_CANCEL));
    cycle();
    fs_inst_pending = 1'b0;
    #1 chk("ao_if_owned", 32'(fsm_state), 32'(PFS_CANCEL));
    cycle();
    icache_data_ok = 1'b0;
    #1;
    chk("ao_req",  32'(icache_req), 32'd1);
    chk("ao_addr", icache_addr, 32'hbfc0_0000);
    chk("ao_dc",   32'(bus.data_cancel), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
